gerador_endereco: RTL and testbench

GERADOR_ENDERECO -- requirements
Module: gerador_endereco

---
 rtl/gerador_endereco_pkg.sv | 14 +
 rtl/gerador_endereco_contador_fase.sv | 21 ++
 rtl/gerador_endereco.sv | 77 +++++++
 tb/tb_gerador_endereco.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/gerador_endereco_pkg.sv
// gerador_endereco_pkg: shared widths and phase numbers for the multicycle address generator.
package gerador_endereco_pkg;
    localparam int LARGURA   = 32;
    localparam int FASES     = 10;
    localparam int FASE_CALC = 6;
    localparam int FASE_PC   = 9;
    localparam int FASE_W    = 4;
    localparam int LARG_IMED = 16;
    localparam int LARG_ALVO = 26;

    function automatic logic seleciona(input logic jump, input logic branch, input logic zero);
        return jump | (branch & zero);
    endfunction
endpackage

// File: rtl/gerador_endereco_contador_fase.sv
// contador_fase: mod-MODULO phase counter with enable and async active-low reset.
module contador_fase #(
    parameter int MODULO = 10,
    parameter int W      = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         habilita,
    output logic [W-1:0] fase
);
    logic [W-1:0] fase_q, fase_d;

    always_comb fase_d = !habilita ? fase_q : (fase_q == W'(MODULO - 1)) ? '0 : fase_q + W'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) fase_q <= '0;
        else        fase_q <= fase_d;
    end

    assign fase = fase_q;
endmodule

// File: rtl/gerador_endereco.sv
// gerador_endereco: forms PC+4 and branch/jump candidates once per instruction and loads PC from the external mux.
module gerador_endereco #(
    parameter int LARGURA    = gerador_endereco_pkg::LARGURA,
    parameter int FASES      = gerador_endereco_pkg::FASES,
    parameter int FASE_CALC  = gerador_endereco_pkg::FASE_CALC,
    parameter int FASE_PC    = gerador_endereco_pkg::FASE_PC,
    parameter logic [LARGURA-1:0] PC_INICIAL = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               habilita,
    input  logic               branch,
    input  logic               zero,
    input  logic               jump,
    input  logic [15:0]        imediato,
    input  logic [25:0]        alvo_jump,
    input  logic [LARGURA-1:0] saidaMux1,
    output logic [LARGURA-1:0] endereco1,
    output logic [LARGURA-1:0] endereco2,
    output logic               control,
    output logic [LARGURA-1:0] pc,
    output logic [3:0]         fase,
    output logic               pc_valido
);
    import gerador_endereco_pkg::*;

    logic [FASE_W-1:0]  fase_w;
    logic               calc, carga;
    logic [LARGURA-1:0] pc4, desvio, alvo, sext;
    logic [LARGURA-1:0] pc_q, pc_d, end1_q, end1_d, end2_q, end2_d;
    logic               ctrl_q, ctrl_d, valido_q, valido_d;

    contador_fase #(.MODULO(FASES), .W(FASE_W)) u_contador_fase (
        .clock    (clock),
        .reset    (reset),
        .habilita (habilita),
        .fase     (fase_w)
    );

    // Jump keeps the top bits of PC+4, as in the MIPS J-format region rule.
    always_comb begin
        calc     = habilita && (fase_w == FASE_W'(FASE_CALC));
        carga    = habilita && (fase_w == FASE_W'(FASE_PC));
        pc4      = pc_q + LARGURA'(4);
        sext     = {{(LARGURA - LARG_IMED){imediato[LARG_IMED-1]}}, imediato};
        desvio   = pc4 + (sext << 2);
        alvo     = {pc4[LARGURA-1 -: LARGURA-LARG_ALVO-2], alvo_jump, 2'b00};
        end1_d   = calc ? pc4 : end1_q;
        end2_d   = calc ? (jump ? alvo : desvio) : end2_q;
        ctrl_d   = calc ? seleciona(jump, branch, zero) : ctrl_q;
        pc_d     = carga ? saidaMux1 : pc_q;
        valido_d = carga;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q     <= PC_INICIAL;
            end1_q   <= '0;
            end2_q   <= '0;
            ctrl_q   <= 1'b0;
            valido_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            end1_q   <= end1_d;
            end2_q   <= end2_d;
            ctrl_q   <= ctrl_d;
            valido_q <= valido_d;
        end
    end

    assign endereco1 = end1_q;
    assign endereco2 = end2_q;
    assign control   = ctrl_q;
    assign pc        = pc_q;
    assign fase      = fase_w;
    assign pc_valido = valido_q;
endmodule

// File: tb/tb_gerador_endereco.sv
// tb_gerador_endereco: directed checks of phase sequencing, candidate formation, freeze and async reset.
module tb_gerador_endereco;
    logic        clock = 1'b0;
    logic        reset, habilita, branch, zero, jump, laco;
    logic [15:0] imediato;
    logic [25:0] alvo_jump;
    logic [31:0] mux_val, saidaMux1, endereco1, endereco2, pc;
    logic        control, pc_valido;
    logic [3:0]  fase;
    int          checks = 0, failures = 0, exp_fase = 0;

    assign saidaMux1 = laco ? endereco1 : mux_val;

    gerador_endereco dut (
        .clock     (clock),
        .reset     (reset),
        .habilita  (habilita),
        .branch    (branch),
        .zero      (zero),
        .jump      (jump),
        .imediato  (imediato),
        .alvo_jump (alvo_jump),
        .saidaMux1 (saidaMux1),
        .endereco1 (endereco1),
        .endereco2 (endereco2),
        .control   (control),
        .pc        (pc),
        .fase      (fase),
        .pc_valido (pc_valido)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
        if (habilita) exp_fase = (exp_fase + 1) % 10;
    endtask

    task automatic goto(input int f);
        while (exp_fase != f) step();
    endtask

    initial begin
        reset = 1'b0; habilita = 1'b1; branch = 1'b0; zero = 1'b0; jump = 1'b0;
        imediato = '0; alvo_jump = '0; mux_val = '0; laco = 1'b1;
        #1;
        chk("reset_fase", {28'd0, fase}, 32'd0);
        chk("reset_pc", pc, 32'd0);
        chk("reset_e1", endereco1, 32'd0);
        chk("reset_valido", {31'd0, pc_valido}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        // first instruction, sequential flow via loop-back
        goto(6);
        chk("seq_fase6", {28'd0, fase}, 32'd6);
        step();
        chk("seq_e1", endereco1, 32'h4);
        chk("seq_ctrl", {31'd0, control}, 32'd0);
        goto(9);
        chk("seq_pc_pre", pc, 32'h0);
        chk("seq_val_pre", {31'd0, pc_valido}, 32'd0);
        step();
        chk("seq_pc", pc, 32'h4);
        chk("seq_val", {31'd0, pc_valido}, 32'd1);
        chk("seq_fase_wrap", {28'd0, fase}, 32'd0);
        step();
        chk("seq_val_off", {31'd0, pc_valido}, 32'd0);
        // move pc to 0x100
        laco = 1'b0; mux_val = 32'h100;
        goto(0);
        chk("pc_100", pc, 32'h100);
        // branch taken, negative offset
        branch = 1'b1; zero = 1'b1; imediato = 16'hFFFE;
        goto(6);
        step();
        chk("br_e2", endereco2, 32'hFC);
        chk("br_ctrl", {31'd0, control}, 32'd1);
        chk("br_e1", endereco1, 32'h104);
        branch = 1'b0; zero = 1'b0; imediato = 16'h0123; jump = 1'b1;
        goto(9);
        chk("br_hold_e2", endereco2, 32'hFC);
        chk("br_hold_ctrl", {31'd0, control}, 32'd1);
        // jump dominates untaken branch
        jump = 1'b0; imediato = '0;
        goto(0);
        jump = 1'b1; branch = 1'b1; zero = 1'b0; alvo_jump = 26'h0000040;
        goto(6);
        step();
        chk("jmp_e2", endereco2, 32'h100);
        chk("jmp_ctrl", {31'd0, control}, 32'd1);
        mux_val = 32'hFFFF_FFFC; jump = 1'b0; branch = 1'b0; alvo_jump = '0;
        goto(0);
        chk("pc_top", pc, 32'hFFFF_FFFC);
        // freeze at calc phase, then wrap of pc+4
        laco = 1'b1;
        goto(6);
        habilita = 1'b0;
        repeat (5) step();
        chk("frz_fase", {28'd0, fase}, 32'd6);
        chk("frz_e1", endereco1, 32'h104);
        chk("frz_pc", pc, 32'hFFFF_FFFC);
        habilita = 1'b1;
        step();
        chk("wrap_e1", endereco1, 32'h0);
        chk("wrap_ctrl", {31'd0, control}, 32'd0);
        goto(9);
        habilita = 1'b0;
        repeat (2) step();
        chk("frz9_pc", pc, 32'hFFFF_FFFC);
        chk("frz9_fase", {28'd0, fase}, 32'd9);
        habilita = 1'b1;
        step();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_val", {31'd0, pc_valido}, 32'd1);
        habilita = 1'b0;
        step();
        chk("val_dis", {31'd0, pc_valido}, 32'd0);
        habilita = 1'b1;
        goto(9);
        step();
        chk("pc_4b", pc, 32'h4);
        // load state then reset mid-cycle at fase 8
        jump = 1'b1; alvo_jump = 26'h10;
        goto(6);
        step();
        chk("pre_rst_e2", endereco2, 32'h40);
        goto(8);
        #2 reset = 1'b0;
        #1;
        chk("rst_fase", {28'd0, fase}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_e1", endereco1, 32'h0);
        chk("rst_e2", endereco2, 32'h0);
        chk("rst_ctrl", {31'd0, control}, 32'd0);
        @(negedge clock);
        step();
        chk("rst_hold", {28'd0, fase}, 32'd0);
        reset = 1'b1; exp_fase = 0;
        step();
        chk("rst_restart", {28'd0, fase}, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
